// File: rtl/mux13_scan_ctrl.sv
// Select sequencer and capture stage for a 13:1 select mux: steps the select
// through enabled channels, samples the mux output after a settle time, and hands off the word.
module mux13_scan_ctrl #(
    parameter int NCH    = 13,
    parameter int SELW   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            cont,
    input  logic [NCH-1:0]  ch_mask,
    output logic [SELW-1:0] s,
    input  logic            mux_o,
    output logic [NCH-1:0]  word,
    output logic            valid,
    input  logic            ready,
    output logic            busy,
    output logic            ovf
);

    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, SEL, SAMP} state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] s_q, s_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NCH-1:0]  mask_q, mask_d;
    logic [NCH-1:0]  buf_q, buf_d;
    logic [NCH-1:0]  word_q, word_d;
    logic            valid_q, valid_d;
    logic            ovf_q, ovf_d;
    logic            complete;

    function automatic logic any_from(input logic [NCH-1:0] m, input int from);
        any_from = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (k >= from && m[k]) any_from = 1'b1;
        end
    endfunction

    // Descending scan so the lowest enabled channel at or above 'from' wins.
    function automatic logic [SELW-1:0] first_from(input logic [NCH-1:0] m, input int from);
        first_from = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (k >= from && m[k]) first_from = SELW'(k);
        end
    endfunction

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        buf_d    = buf_q;
        word_d   = word_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        complete = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d = ch_mask;
                    buf_d  = '0;
                    ovf_d  = 1'b0;
                    if (|ch_mask) begin
                        state_d = SEL;
                        s_d     = first_from(ch_mask, 0);
                        cnt_d   = '0;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            SEL: begin
                if (cnt_q == CW'(SETTLE - 1)) state_d = SAMP;
                else                          cnt_d   = cnt_q + 1'b1;
            end
            SAMP: begin
                // An empty mask under continuous mode also lands here; nothing is captured then.
                if (mask_q[int'(s_q)]) buf_d[int'(s_q)] = mux_o;
                if (any_from(mask_q, int'(s_q) + 1)) begin
                    state_d = SEL;
                    s_d     = first_from(mask_q, int'(s_q) + 1);
                    cnt_d   = '0;
                end else begin
                    complete = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete) begin
            word_d  = buf_d;
            valid_d = 1'b1;
            if (valid_q && !ready) ovf_d = 1'b1;
            if (cont) begin
                mask_d = ch_mask;
                buf_d  = '0;
                if (|ch_mask) begin
                    state_d = SEL;
                    s_d     = first_from(ch_mask, 0);
                    cnt_d   = '0;
                end else begin
                    state_d = SAMP;
                end
            end else begin
                state_d = IDLE;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            buf_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            buf_q   <= buf_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s     = s_q;
    assign word  = word_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mux13_scan_ctrl.sv
// Directed bench for mux13_scan_ctrl: full, sparse and empty scans, overrun,
// completion coinciding with a handshake, and reset in the middle of a scan.
module tb_mux13_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cont = 1'b0;
    logic        ready = 1'b0;
    logic        mux_o;
    logic [12:0] ch_mask = '0;
    logic [12:0] pat = '0;
    logic [12:0] word;
    logic [3:0]  s;
    logic        valid, busy, ovf;

    int testsRun = 0;
    int testsFailed = 0;

    mux13_scan_ctrl #(.NCH(13), .SELW(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .ch_mask(ch_mask),
        .s(s), .mux_o(mux_o), .word(word), .valid(valid), .ready(ready),
        .busy(busy), .ovf(ovf)
    );

    // Behavioural 13:1 mux driven by the current data pattern.
    assign mux_o = (s < 4'd13) ? pat[s] : 1'b0;

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one edge (edge 0); returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [12:0] mask, input logic c, input logic [12:0] p);
        ch_mask = mask;
        cont    = c;
        pat     = p;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        tick();
        checkOutput("consume_valid", 32'(valid), 32'd0);
        ready = 1'b0;
    endtask

    initial begin
        #12;
        checkOutput("rst_s", 32'(s), 32'd0);
        checkOutput("rst_word", 32'(word), 32'd0);
        checkOutput("rst_valid", 32'(valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] full scan");
        applyStimulus(13'h1FFF, 1'b0, 13'h1A5B);
        checkOutput("full_busy0", 32'(busy), 32'd1);
        checkOutput("full_s0", 32'(s), 32'd0);
        for (int k = 1; k <= 25; k++) begin
            tick();
            checkOutput($sformatf("full_s_e%0d", k), 32'(s), 32'(k / 2));
        end
        checkOutput("full_valid_e25", 32'(valid), 32'd0);
        tick();
        checkOutput("full_valid", 32'(valid), 32'd1);
        checkOutput("full_word", 32'(word), 32'h1A5B);
        checkOutput("full_busy", 32'(busy), 32'd0);
        checkOutput("full_ovf", 32'(ovf), 32'd0);
        checkOutput("full_s_hold", 32'(s), 32'd12);
        consume();

        $display("[TB] sparse mask");
        applyStimulus(13'h1001, 1'b0, 13'h1A5B);
        checkOutput("sparse_s0", 32'(s), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            checkOutput($sformatf("sparse_s_e%0d", k), 32'(s), (k < 2) ? 32'd0 : 32'd12);
        end
        checkOutput("sparse_valid_e3", 32'(valid), 32'd0);
        tick();
        checkOutput("sparse_valid", 32'(valid), 32'd1);
        checkOutput("sparse_word", 32'(word), 32'h1001);
        consume();

        $display("[TB] zero mask");
        applyStimulus(13'h0000, 1'b0, 13'h1A5B);
        checkOutput("zero_valid", 32'(valid), 32'd1);
        checkOutput("zero_word", 32'(word), 32'd0);
        checkOutput("zero_busy", 32'(busy), 32'd0);
        checkOutput("zero_s", 32'(s), 32'd12);
        consume();

        $display("[TB] overrun");
        applyStimulus(13'h1FFF, 1'b1, 13'h1A5B);
        repeat (25) tick();
        tick();
        checkOutput("ovr1_valid", 32'(valid), 32'd1);
        checkOutput("ovr1_word", 32'(word), 32'h1A5B);
        checkOutput("ovr1_ovf", 32'(ovf), 32'd0);
        checkOutput("ovr1_busy", 32'(busy), 32'd1);
        checkOutput("ovr1_s", 32'(s), 32'd0);
        cont = 1'b0;
        pat  = 13'h0F0F;
        repeat (25) tick();
        checkOutput("ovr2_ovf_e51", 32'(ovf), 32'd0);
        tick();
        checkOutput("ovr2_ovf", 32'(ovf), 32'd1);
        checkOutput("ovr2_word", 32'(word), 32'h0F0F);
        checkOutput("ovr2_busy", 32'(busy), 32'd0);

        $display("[TB] completion with handshake");
        applyStimulus(13'h1FFF, 1'b0, 13'h1555);
        checkOutput("restart_ovf_clear", 32'(ovf), 32'd0);
        repeat (25) tick();
        ready = 1'b1;
        tick();
        checkOutput("hs_valid", 32'(valid), 32'd1);
        checkOutput("hs_ovf", 32'(ovf), 32'd0);
        checkOutput("hs_word", 32'(word), 32'h1555);
        ready = 1'b0;

        $display("[TB] reset mid-scan");
        applyStimulus(13'h1FFF, 1'b0, 13'h1A5B);
        repeat (6) tick();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_s", 32'(s), 32'd0);
        checkOutput("mid_rst_word", 32'(word), 32'd0);
        checkOutput("mid_rst_valid", 32'(valid), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_ovf", 32'(ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        applyStimulus(13'h1FFF, 1'b0, 13'h1A5B);
        repeat (25) tick();
        checkOutput("post_rst_valid_e25", 32'(valid), 32'd0);
        tick();
        checkOutput("post_rst_valid", 32'(valid), 32'd1);
        checkOutput("post_rst_word", 32'(word), 32'h1A5B);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
